// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants and FSM state type for the mux scan sequencer.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} scan_state_t;
endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: finds the lowest enabled channel, or the next enabled one above cur_i.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    input  logic              first_i,
    output logic [SEL_W-1:0]  nxt_o,
    output logic              found_o
);
    always_comb begin
        nxt_o   = '0;
        found_o = 1'b0;
        // Scan downward so the lowest qualifying channel is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || i > int'(cur_i))) begin
                nxt_o   = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: sweeps enabled mux channels, samples each after a settle time,
// and hands a snapshot downstream over valid/ready with sticky overrun detection.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  s,
    output logic              busy,
    output logic [NUM_CH-1:0] snap,
    output logic              snap_valid,
    input  logic              snap_ready,
    output logic              overrun,
    input  logic              clr_ovr
);
    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  s_q, s_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] shadow_q, shadow_d;
    logic [NUM_CH-1:0] snap_q, snap_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              load;
    logic [SEL_W-1:0]  nxt;
    logic              found;

    // In IDLE the live enable mask picks the first channel; mid-sweep the latched mask is used.
    mux_scan_next_ch u_next (
        .mask_i  (state_q == IDLE ? ch_en : mask_q),
        .cur_i   (s_q),
        .first_i (state_q == IDLE),
        .nxt_o   (nxt),
        .found_o (found)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        mask_d   = mask_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((start | cont) && |ch_en) begin
                    mask_d  = ch_en;
                    s_d     = nxt;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) state_d = SAMPLE;
                else cnt_d = cnt_q + 1'b1;
            end
            SAMPLE: begin
                shadow_d[s_q] = mux_out;
                if (found) begin
                    s_d     = nxt;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else begin
                    load    = 1'b1;
                    snap_d  = shadow_d & mask_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = load | (valid_q & ~snap_ready);
        ovr_d   = (load & valid_q & ~snap_ready) | (ovr_q & ~clr_ovr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            s_q      <= '0;
            mask_q   <= '0;
            shadow_q <= '0;
            snap_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign s          = s_q;
    assign busy       = state_q != IDLE;
    assign snap       = snap_q;
    assign snap_valid = valid_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed table-driven sweeps plus hand-written handshake/reset corners.
module tb_mux_scan_sequencer;
    localparam int SC  = 2;
    localparam int PER = SC + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] ch_en = '0;
    logic [3:0] mux_in = '0;
    logic       mux_out;
    logic [1:0] s;
    logic       busy;
    logic [3:0] snap;
    logic       snap_valid;
    logic       snap_ready = 1'b0;
    logic       overrun;
    logic       clr_ovr = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [3:0] en;
        logic [3:0] mi;
        logic [3:0] exp_snap;
    } vec_t;

    always #5 clk = ~clk;
    assign mux_out = mux_in[s];

    mux_scan_sequencer #(.SETTLE_CYC(SC)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_en(ch_en),
        .mux_out(mux_out), .s(s), .busy(busy), .snap(snap),
        .snap_valid(snap_valid), .snap_ready(snap_ready),
        .overrun(overrun), .clr_ovr(clr_ovr)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] nth_ch(input logic [3:0] en, input int n);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                if (c == n) return 2'(i);
                c++;
            end
        end
        return 2'd0;
    endfunction

    task automatic run_sweep(input logic [3:0] en, input logic [3:0] mi,
                             input logic [3:0] exp_snap, input bit acc);
        int n = $countones(en);
        @(negedge clk);
        ch_en  = en;
        mux_in = mi;
        start  = 1'b1;
        for (int k = 0; k <= PER * n; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k < PER * n) begin
                chk("busy_mid", 8'(busy), 8'd1);
                chk("s_seq", 8'(s), 8'(nth_ch(en, k / PER)));
            end else begin
                chk("busy_end", 8'(busy), 8'd0);
                chk("snap", 8'(snap), 8'(exp_snap));
                chk("valid_end", 8'(snap_valid), 8'd1);
                chk("ovr_end", 8'(overrun), 8'd0);
            end
        end
        if (acc) begin
            snap_ready = 1'b1;
            @(negedge clk);
            snap_ready = 1'b0;
            chk("valid_acc", 8'(snap_valid), 8'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[5];
        bit seen;
        vt[0] = '{4'b1111, 4'b1010, 4'b1010};
        vt[1] = '{4'b0101, 4'b0101, 4'b0101};
        vt[2] = '{4'b1000, 4'b1111, 4'b1000};
        vt[3] = '{4'b0110, 4'b1001, 4'b0000};
        vt[4] = '{4'b1011, 4'b1110, 4'b1010};

        repeat (2) @(negedge clk);
        chk("reset_outs", {1'b0, s, busy, snap_valid, overrun, 2'b0}, 8'd0);
        chk("reset_snap", 8'(snap), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", {s, busy, snap_valid, overrun, snap}, 8'd0);

        // start with an empty mask must never begin a sweep
        ch_en = 4'b0000;
        mux_in = 4'b1111;
        start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("empty_mask", {3'b0, s, busy, snap_valid}, 8'd0);
        end
        start = 1'b0;

        for (int v = 0; v < 5; v++) run_sweep(vt[v].en, vt[v].mi, vt[v].exp_snap, 1'b1);

        // continuous mode with downstream stalled: second load overruns
        @(negedge clk);
        ch_en = 4'b1111;
        mux_in = 4'b1010;
        cont = 1'b1;
        repeat (13) @(negedge clk);
        chk("cont_valid1", 8'(snap_valid), 8'd1);
        chk("cont_ovr1", 8'(overrun), 8'd0);
        chk("cont_idle", 8'(busy), 8'd0);
        mux_in = 4'b0101;
        repeat (13) @(negedge clk);
        chk("cont_ovr2", 8'(overrun), 8'd1);
        chk("cont_valid2", 8'(snap_valid), 8'd1);
        chk("cont_snap2", 8'(snap), 8'h5);
        cont = 1'b0;
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("clr_ovr", 8'(overrun), 8'd0);
        chk("cont_stop", 8'(busy), 8'd0);
        snap_ready = 1'b1;
        @(negedge clk);
        chk("cont_acc", 8'(snap_valid), 8'd0);

        // continuous mode with ready held high never overruns
        cont = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            seen |= overrun;
            if (k == 12) chk("rdy_valid", 8'(snap_valid), 8'd1);
            if (k == 13) chk("rdy_clear", 8'(snap_valid), 8'd0);
        end
        cont = 1'b0;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("rdy_idle", 8'(busy), 8'd0);
        @(negedge clk);
        chk("rdy_no_ovr", 8'(seen | overrun), 8'd0);
        chk("rdy_valid_end", 8'(snap_valid), 8'd0);
        snap_ready = 1'b0;

        // asynchronous reset in the settle phase of channel 2
        @(negedge clk);
        ch_en = 4'b1111;
        mux_in = 4'b1010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_s", 8'(s), 8'd2);
        rst = 1'b1;
        #1;
        chk("async_rst", {s, busy, snap_valid, overrun, snap}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(4'b1111, 4'b0110, 4'b0110, 1'b0);

        // accept coinciding with a new load: no overrun, valid stays
        @(negedge clk);
        ch_en = 4'b0001;
        mux_in = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        snap_ready = 1'b1;
        @(negedge clk);
        chk("acc_load_valid", 8'(snap_valid), 8'd1);
        chk("acc_load_snap", 8'(snap), 8'h1);
        chk("acc_load_ovr", 8'(overrun), 8'd0);
        @(negedge clk);
        snap_ready = 1'b0;
        chk("acc_load_clear", 8'(snap_valid), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Upstream controller for the 4:1 single-bit channel mux. It drives the mux select `s`, holds each select for a programmable settle time, and samples the mux output back in. Results are assembled into a 4-bit snapshot of all enabled channels and handed downstream over a valid/ready handshake. It supports one-shot and continuous sweeps, plus a per-channel enable mask.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles `s` is held stable before the sample cycle; legal range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-shot sweep request; sampled in IDLE only.
- `cont` in 1: continuous mode; while high, a new sweep starts every time IDLE is entered.
- `ch_en` in 4: channel enable mask; latched at sweep start.
- `mux_out` in 1: mux output, returned from the mux.
- `s` out 2: mux select.
- `busy` out 1: sweep in progress.
- `snap` out 4: snapshot; bit i = channel i; disabled channels read 0.
- `snap_valid` out 1: snapshot available.
- `snap_ready` in 1: downstream accepts the snapshot.
- `overrun` out 1: sticky; a valid snapshot was overwritten before acceptance.
- `clr_ovr` in 1: clears `overrun`.

## Operation
- Reset values: all outputs 0. FSM = IDLE. Internal shadow register, mask latch and counter = 0.
- State IDLE:
  - If (`start` | `cont`) and `ch_en` != 0: latch `ch_en`, set `s` = lowest enabled channel, go to SETTLE.
  - `start` with `ch_en` = 0 is ignored; `busy` stays 0.
  - `s` holds its last value.
- State SETTLE:
  - Counter runs 0..SETTLE_CYC-1 with `s` stable.
  - After the last count, go to SAMPLE.
- State SAMPLE, one cycle:
  - Register `mux_out` into shadow bit `s`.
  - If a higher enabled channel exists, set `s` to it, clear the counter, and go to SETTLE.
  - Otherwise load `snap` from the shadow (disabled bits = 0), set `snap_valid` = 1, and go to IDLE.
  - Channel order is strictly ascending and disabled channels are skipped.
- `busy` = 1 in SETTLE and SAMPLE, 0 in IDLE.
- `start` and `ch_en` changes during a sweep are ignored.
- Output handshake:
  - `snap_valid` clears on an edge where `snap_valid` & `snap_ready` and no new load occurs.
  - `snap` is stable while `snap_valid` is high and not accepted.
  - Load with `snap_valid` = 1 and `snap_ready` = 0: overwrite `snap`, keep `snap_valid` = 1, set `overrun`.
  - Load in the same edge as an accept: new data loads, `snap_valid` stays 1, no overrun.
- `overrun` set and `clr_ovr` on the same edge: set wins.
- Reset mid-sweep: the partial sweep is discarded and all state returns to reset values immediately.

## Timing
- The sweep starts at the edge E0 where IDLE samples the request; `busy` and the new `s` are visible after E0.
- Each enabled channel takes SETTLE_CYC+1 cycles.
- With N enabled channels, `snap` and `snap_valid` update at edge E0 + N·(SETTLE_CYC+1), and `busy` falls at that same edge.
- Continuous-mode period: N·(SETTLE_CYC+1)+1 cycles; exactly one IDLE cycle falls between sweeps.
- `mux_out` is treated as combinational from `s`. It is sampled SETTLE_CYC+1 edges after `s` changes.
- No combinational path from inputs to outputs.

## Structure
- Package `mux_scan_pkg`:
  - `NUM_CH` = 4
  - `SEL_W` = 2
  - FSM enum `scan_state_t` {IDLE, SETTLE, SAMPLE}
  - counter width `CNT_W` = 8
- Sub-module `mux_scan_next_ch`: combinational function of (mask, current channel, first flag) returning the next enabled channel plus a found flag. It is used for both sweep start and channel advance.
- The top module holds the FSM, settle counter, shadow and output registers, and handshake/overrun logic.

## Test plan
- SETTLE_CYC=2, `ch_en`=4'b1111, mux inputs I3..I0 = 1,0,1,0; `start` pulse at E0 → `s` sequence 0,1,2,3 with 3 cycles each; `snap`=4'b1010 and `snap_valid`=1 at E0+12; `busy` low from E0+12.
- `ch_en`=4'b0101, inputs I3..I0 = 0,1,0,1 → `s` visits only 0 and 2; `snap`=4'b0101 at E0+6.
- `ch_en`=0 with `start` → `busy`, `snap_valid` and `s` all stay 0 indefinitely.
- `cont`=1, `ch_en`=4'b1111, `snap_ready`=0 → first `snap_valid` at E0+12; second load at E0+25 sets `overrun`=1. `clr_ovr` pulse clears it. Repeat with `snap_ready`=1 held → `overrun` never sets.
- Assert `rst` mid-SETTLE of channel 2 → all outputs 0 asynchronously. After release, a `start` pulse gives a full fresh sweep with correct `snap`.
- `snap_ready` asserted on the exact load edge while the previous snapshot is still pending → new `snap` loaded, `snap_valid` stays 1, `overrun` stays 0.
